lock_ctrl_fsm: RTL and testbench

LOCK_CTRL_FSM -- requirements
Module: lock_ctrl_fsm

---
 rtl/lock_ctrl_fsm_if.sv | 13 +
 rtl/lock_ctrl_fsm.sv | 76 +++++++
 tb/tb_lock_ctrl_fsm.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lock_ctrl_fsm_if.sv
// lock_ctrl_fsm_if: user inputs, password register feedback and lock status bundle
interface lock_ctrl_fsm_if;
    logic [3:0] inps;
    logic       enter;
    logic       chg;
    logic [3:0] pass;
    logic [3:0] state;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fails;
    modport master (output inps, enter, chg, pass, input state, unlocked, alarm, fails);
    modport slave (input inps, enter, chg, pass, output state, unlocked, alarm, fails);
endinterface

// File: rtl/lock_ctrl_fsm.sv
// lock_ctrl_fsm: code lock with failure lockout, idle auto-relock and password change request
module lock_ctrl_fsm #(
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT  = 16,
    parameter int OPEN_TO  = 64
) (
    input logic           Clk,
    input logic           Resetn,
    lock_ctrl_fsm_if.slave bus
);
    typedef enum logic [3:0] {LK = 4'b0000, OP = 4'b0001, CH = 4'b0011, AL = 4'b0100} state_t;
    state_t     st, st_n;
    logic       enter_q, press, unlocked_q, alarm_q;
    logic [1:0] fails_q, fails_n;
    logic [2:0] fails_inc;
    logic [7:0] open_tmr, open_n, lock_tmr, lock_n;
    assign press     = bus.enter & ~enter_q;
    assign fails_inc = {1'b0, fails_q} + 3'd1;
    always_comb begin
        st_n    = LK;
        fails_n = fails_q;
        open_n  = open_tmr;
        lock_n  = lock_tmr;
        case (st)
            LK: if (press) begin
                if (bus.inps == bus.pass) begin
                    st_n    = OP;
                    fails_n = '0;
                    open_n  = 8'(OPEN_TO);
                end else if (fails_inc < 3'(MAX_FAIL)) begin
                    fails_n = fails_inc[1:0];
                end else begin
                    st_n    = AL;
                    fails_n = 2'(MAX_FAIL);
                    lock_n  = 8'(LOCKOUT);
                end
            end
            OP: begin
                open_n = open_tmr == '0 ? '0 : open_tmr - 8'd1;
                // a press wins over an expiring idle timer
                st_n   = press ? (bus.chg ? CH : LK) : (open_tmr <= 8'd1 ? LK : OP);
            end
            CH: st_n = LK;
            AL: begin
                lock_n  = lock_tmr == '0 ? '0 : lock_tmr - 8'd1;
                st_n    = lock_tmr <= 8'd1 ? LK : AL;
                fails_n = lock_tmr <= 8'd1 ? 2'd0 : fails_q;
            end
            default: st_n = LK;
        endcase
    end
    // enter_q resets high so an enter held through reset is not a press
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            st         <= LK;
            enter_q    <= 1'b1;
            fails_q    <= '0;
            open_tmr   <= '0;
            lock_tmr   <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            st         <= st_n;
            enter_q    <= bus.enter;
            fails_q    <= fails_n;
            open_tmr   <= open_n;
            lock_tmr   <= lock_n;
            unlocked_q <= st_n == OP;
            alarm_q    <= st_n == AL;
        end
    end
    assign bus.state    = st;
    assign bus.unlocked = unlocked_q;
    assign bus.alarm    = alarm_q;
    assign bus.fails    = fails_q;
endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb_lock_ctrl_fsm: vector table plus multi-cycle sequences for lock_ctrl_fsm
module tb_lock_ctrl_fsm;
    localparam logic [3:0] LK = 4'b0000, OP = 4'b0001, CH = 4'b0011, AL = 4'b0100;
    typedef struct {
        logic [3:0] inps;
        logic       enter;
        logic       chg;
        logic [3:0] st;
        logic       ul;
        logic       al;
        logic [1:0] fl;
    } vec_t;
    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic [3:0] pass_r;
    int         n_cmp = 0, n_bad = 0;
    vec_t       vt [15];
    lock_ctrl_fsm_if bus ();
    lock_ctrl_fsm #(.MAX_FAIL(3), .LOCKOUT(16), .OPEN_TO(64)) dut (.Clk(Clk), .Resetn(Resetn), .bus(bus));
    always #5 Clk = ~Clk;
    // downstream password register: captures inps on the edge leaving CH
    always @(posedge Clk or negedge Resetn)
        if (!Resetn) pass_r <= 4'b0110;
        else if (bus.state == CH) pass_r <= bus.inps;
    assign bus.pass = pass_r;
    task automatic chk(input string nm, input logic [3:0] s, input logic u, input logic a, input logic [1:0] f);
        n_cmp++;
        if ({bus.state, bus.unlocked, bus.alarm, bus.fails} !== {s, u, a, f}) begin
            n_bad++;
            $display("FAIL %s: got state=%h unl=%b al=%b fails=%0d, want state=%h unl=%b al=%b fails=%0d",
                     nm, bus.state, bus.unlocked, bus.alarm, bus.fails, s, u, a, f);
        end
    endtask
    task automatic step(input logic [3:0] i, input logic e, input logic c);
        bus.inps = i; bus.enter = e; bus.chg = c;
        @(posedge Clk); #1;
    endtask
    task automatic press(input logic [3:0] i, input logic c);
        step(i, 1'b0, c);
        step(i, 1'b1, c);
    endtask
    initial begin
        vt[0]  = '{4'd6, 1'b0, 1'b0, LK, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{4'd6, 1'b1, 1'b0, OP, 1'b1, 1'b0, 2'd0};
        vt[2]  = '{4'd6, 1'b0, 1'b0, OP, 1'b1, 1'b0, 2'd0};
        vt[3]  = '{4'd6, 1'b1, 1'b0, LK, 1'b0, 1'b0, 2'd0};
        vt[4]  = '{4'd1, 1'b0, 1'b0, LK, 1'b0, 1'b0, 2'd0};
        vt[5]  = '{4'd1, 1'b1, 1'b0, LK, 1'b0, 1'b0, 2'd1};
        vt[6]  = '{4'd1, 1'b1, 1'b0, LK, 1'b0, 1'b0, 2'd1};
        vt[7]  = '{4'd1, 1'b0, 1'b0, LK, 1'b0, 1'b0, 2'd1};
        vt[8]  = '{4'd1, 1'b1, 1'b0, LK, 1'b0, 1'b0, 2'd2};
        vt[9]  = '{4'd1, 1'b0, 1'b0, LK, 1'b0, 1'b0, 2'd2};
        vt[10] = '{4'd1, 1'b1, 1'b0, AL, 1'b0, 1'b1, 2'd3};
        vt[11] = '{4'd1, 1'b0, 1'b0, AL, 1'b0, 1'b1, 2'd3};
        vt[12] = '{4'd1, 1'b1, 1'b0, AL, 1'b0, 1'b1, 2'd3};
        vt[13] = '{4'd6, 1'b0, 1'b0, AL, 1'b0, 1'b1, 2'd3};
        vt[14] = '{4'd6, 1'b1, 1'b0, AL, 1'b0, 1'b1, 2'd3};
        bus.inps = 4'd0; bus.enter = 1'b0; bus.chg = 1'b0;
        @(posedge Clk); #1;
        chk("reset", LK, 1'b0, 1'b0, 2'd0);
        Resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(vt[i].inps, vt[i].enter, vt[i].chg);
            chk($sformatf("vec%0d", i), vt[i].st, vt[i].ul, vt[i].al, vt[i].fl);
        end
        // alarm lasts 16 cycles total; 5 already seen, presses keep coming
        for (int i = 0; i < 11; i++) begin
            step(4'd6, 1'(i % 2), 1'b0);
            chk($sformatf("al_hold%0d", i), AL, 1'b0, 1'b1, 2'd3);
        end
        step(4'd6, 1'b0, 1'b0);
        chk("al_end", LK, 1'b0, 1'b0, 2'd0);
        press(4'd6, 1'b0);
        chk("unlock_old", OP, 1'b1, 1'b0, 2'd0);
        press(4'd10, 1'b1);
        chk("chg_enter", CH, 1'b0, 1'b0, 2'd0);
        step(4'd10, 1'b1, 1'b0);
        chk("chg_exit", LK, 1'b0, 1'b0, 2'd0);
        press(4'd6, 1'b0);
        chk("old_rejected", LK, 1'b0, 1'b0, 2'd1);
        press(4'd10, 1'b0);
        chk("new_unlocks", OP, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 63; i++) begin
            step(4'd10, 1'b0, 1'b0);
            chk("idle_open", OP, 1'b1, 1'b0, 2'd0);
        end
        step(4'd10, 1'b0, 1'b0);
        chk("idle_relock", LK, 1'b0, 1'b0, 2'd0);
        press(4'd10, 1'b0);
        for (int i = 0; i < 63; i++) step(4'd10, 1'b0, 1'b0);
        chk("idle_open2", OP, 1'b1, 1'b0, 2'd0);
        step(4'd10, 1'b1, 1'b0);
        chk("to_press_lk", LK, 1'b0, 1'b0, 2'd0);
        press(4'd10, 1'b1);
        for (int i = 0; i < 63; i++) step(4'd10, 1'b0, 1'b1);
        step(4'd10, 1'b1, 1'b1);
        chk("to_press_ch", CH, 1'b0, 1'b0, 2'd0);
        step(4'd10, 1'b0, 1'b0);
        chk("to_ch_exit", LK, 1'b0, 1'b0, 2'd0);
        bus.inps = 4'd6; bus.enter = 1'b1;
        Resetn = 1'b0;
        @(posedge Clk); #1;
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'd6, 1'b1, 1'b0);
            chk("held_enter", LK, 1'b0, 1'b0, 2'd0);
        end
        step(4'd6, 1'b0, 1'b0);
        step(4'd6, 1'b1, 1'b0);
        chk("held_release", OP, 1'b1, 1'b0, 2'd0);
        step(4'd1, 1'b0, 1'b0);
        step(4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) press(4'd1, 1'b0);
        chk("al_again", AL, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 11; i++) step(4'd1, 1'b0, 1'b0);
        chk("al_5left", AL, 1'b0, 1'b1, 2'd3);
        #2 Resetn = 1'b0;
        #1 chk("async_rst", LK, 1'b0, 1'b0, 2'd0);
        @(posedge Clk); #1;
        Resetn = 1'b1;
        step(4'd1, 1'b0, 1'b0);
        chk("post_rst", LK, 1'b0, 1'b0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
